// File: rtl/nf_pkg.sv
// Shared NAND read-path constants, controller state encoding and the
// helper that picks which column/row byte goes out on each address cycle.
package nf_pkg;

  localparam logic [7:0]  CMD_READ0 = 8'h00;
  localparam logic [7:0]  CMD_READ1 = 8'h30;

  localparam int          TWB_CYC   = 10;
  localparam logic [19:0] TO_CYC    = 20'd900000;

  // Index of the last of the five address cycles.
  localparam logic [2:0]  ADDR_LAST = 3'd4;

  typedef enum logic [3:0] {
    IDLE,
    CMD1,
    ADDR,
    CMD2,
    WAIT_WB,
    WAIT_RB,
    RD_REQ,
    RD_WAIT,
    FIN
  } nf_state_e;

  // Address cycle order: col low, col high, row low, row mid, row high.
  function automatic logic [7:0] addr_byte(input logic [15:0] col,
                                           input logic [23:0] row,
                                           input logic [2:0]  sel);
    logic [7:0] b;
    case (sel)
      3'd0:    b = col[7:0];
      3'd1:    b = col[15:8];
      3'd2:    b = row[7:0];
      3'd3:    b = row[15:8];
      default: b = row[23:16];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/nf_rb_timer.sv
// Loadable down-counter with a done flag; used both for the tWB blanking
// window and for the ready/busy timeout.
module nf_rb_timer #(
  parameter int W = 20
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] count;

  // Load wins; otherwise count down and park at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/nf_page_read_ctrl.sv
// NAND page read sequencer: READ0, five address cycles, READ1 through the
// byte-write engine, wait tWB then R/B, then one byte-read request per data
// byte with each result written into the page buffer. All outputs are
// registered so the engines and the buffer see clean single-cycle pulses.
module nf_page_read_ctrl #(
  parameter int              BCNT_W  = 12,
  parameter int              TWB_CYC = nf_pkg::TWB_CYC,
  parameter int              TO_W    = 20,
  parameter logic [TO_W-1:0] TO_CYC  = TO_W'(nf_pkg::TO_CYC)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [15:0]       col_addr,
  input  logic [23:0]       row_addr,
  input  logic [BCNT_W-1:0] byte_cnt,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              wb_en,
  output logic [7:0]        wb_data,
  output logic              wb_cle,
  output logic              wb_ale,
  input  logic              wb_ack,
  output logic              rb_en,
  input  logic [7:0]        rb_data,
  input  logic              rb_ack,
  input  logic              nf_rb_n,
  output logic              buf_we,
  output logic [BCNT_W-1:0] buf_addr,
  output logic [7:0]        buf_wdata
);

  import nf_pkg::*;

  nf_state_e         state_q, state_d;
  logic [2:0]        addr_cnt_q, addr_cnt_d;
  logic [BCNT_W-1:0] idx_q, idx_d;
  logic [BCNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]       col_q, col_d;
  logic [23:0]       row_q, row_d;

  logic              busy_d, done_d, err_d;
  logic              wb_en_d, wb_cle_d, wb_ale_d;
  logic [7:0]        wb_data_d;
  logic              rb_en_d;
  logic              buf_we_d;
  logic [BCNT_W-1:0] buf_addr_d;
  logic [7:0]        buf_wdata_d;

  logic              tmr_load;
  logic [TO_W-1:0]   tmr_val;
  logic              tmr_done;
  logic              fail;

  nf_rb_timer #(.W(TO_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  // Next state and next registered outputs; request pulses are raised on the
  // transition into a state so they appear in that state's first cycle.
  always_comb begin
    state_d     = state_q;
    addr_cnt_d  = addr_cnt_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    col_d       = col_q;
    row_d       = row_q;
    busy_d      = busy;
    done_d      = 1'b0;
    err_d       = 1'b0;
    wb_en_d     = 1'b0;
    wb_data_d   = wb_data;
    wb_cle_d    = wb_cle;
    wb_ale_d    = wb_ale;
    rb_en_d     = 1'b0;
    buf_we_d    = 1'b0;
    buf_addr_d  = buf_addr;
    buf_wdata_d = buf_wdata;
    tmr_load    = 1'b0;
    tmr_val     = '0;
    fail        = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start && !abort) begin
          col_d      = col_addr;
          row_d      = row_addr;
          cnt_d      = byte_cnt;
          addr_cnt_d = 3'd0;
          idx_d      = '0;
          busy_d     = 1'b1;
          wb_en_d    = 1'b1;
          wb_data_d  = CMD_READ0;
          wb_cle_d   = 1'b1;
          wb_ale_d   = 1'b0;
          state_d    = CMD1;
        end
      end

      CMD1: begin
        if (wb_ack) begin
          addr_cnt_d = 3'd0;
          wb_en_d    = 1'b1;
          wb_data_d  = addr_byte(col_q, row_q, 3'd0);
          wb_cle_d   = 1'b0;
          wb_ale_d   = 1'b1;
          state_d    = ADDR;
        end
      end

      ADDR: begin
        if (wb_ack) begin
          wb_en_d = 1'b1;
          if (addr_cnt_q == ADDR_LAST) begin
            wb_data_d = CMD_READ1;
            wb_cle_d  = 1'b1;
            wb_ale_d  = 1'b0;
            state_d   = CMD2;
          end else begin
            addr_cnt_d = addr_cnt_q + 3'd1;
            wb_data_d  = addr_byte(col_q, row_q, addr_cnt_q + 3'd1);
          end
        end
      end

      CMD2: begin
        if (wb_ack) begin
          wb_data_d = 8'h00;
          wb_cle_d  = 1'b0;
          tmr_load  = 1'b1;
          tmr_val   = TO_W'(TWB_CYC - 1);
          state_d   = WAIT_WB;
        end
      end

      WAIT_WB: begin
        if (abort) begin
          fail = 1'b1;
        end else if (tmr_done) begin
          tmr_load = 1'b1;
          tmr_val  = TO_CYC - TO_W'(1);
          state_d  = WAIT_RB;
        end
      end

      WAIT_RB: begin
        if (abort) begin
          fail = 1'b1;
        end else if (nf_rb_n) begin
          state_d = (cnt_q == '0) ? FIN : RD_REQ;
        end else if (tmr_done) begin
          fail = 1'b1;
        end
      end

      RD_REQ: begin
        if (abort) begin
          fail = 1'b1;
        end else begin
          rb_en_d = 1'b1;
          state_d = RD_WAIT;
        end
      end

      RD_WAIT: begin
        if (rb_ack) begin
          buf_we_d    = 1'b1;
          buf_addr_d  = idx_q;
          buf_wdata_d = rb_data;
          if (idx_q == cnt_q - BCNT_W'(1)) begin
            state_d = FIN;
          end else begin
            idx_d   = idx_q + BCNT_W'(1);
            state_d = RD_REQ;
          end
        end
      end

      FIN: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (fail) begin
      err_d   = 1'b1;
      busy_d  = 1'b0;
      state_d = IDLE;
    end
  end

  // State, latched request and all outputs; reset drops every request at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      addr_cnt_q <= 3'd0;
      idx_q      <= '0;
      cnt_q      <= '0;
      col_q      <= '0;
      row_q      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      wb_en      <= 1'b0;
      wb_data    <= 8'h00;
      wb_cle     <= 1'b0;
      wb_ale     <= 1'b0;
      rb_en      <= 1'b0;
      buf_we     <= 1'b0;
      buf_addr   <= '0;
      buf_wdata  <= 8'h00;
    end else begin
      state_q    <= state_d;
      addr_cnt_q <= addr_cnt_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      col_q      <= col_d;
      row_q      <= row_d;
      busy       <= busy_d;
      done       <= done_d;
      err        <= err_d;
      wb_en      <= wb_en_d;
      wb_data    <= wb_data_d;
      wb_cle     <= wb_cle_d;
      wb_ale     <= wb_ale_d;
      rb_en      <= rb_en_d;
      buf_we     <= buf_we_d;
      buf_addr   <= buf_addr_d;
      buf_wdata  <= buf_wdata_d;
    end
  end

endmodule
